// File: rtl/piso_stream_out.sv
`default_nettype none
// ============================================================================
//  Module      : piso_stream_out
//  Description : Word FIFO feeding a parallel-in/serial-out shifter; streams
//                buffered words one bit per read cycle, back-to-back.
//                Optional macro PISO_PARITY_EN appends an even-parity bit
//                after every word.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_stream_out #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [DATA_W-1:0]        parallel_in,
    input  logic                     wr_in,
    output logic                     input_rdy,
    input  logic                     output_read_in,
    output logic                     output_rdy,
    output logic                     serial_out,
    output logic                     serial_valid,
    output logic                     serial_last,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_AW = $clog2(DEPTH);
`ifdef PISO_PARITY_EN
    localparam int c_NBITS = DATA_W + 1;
`else
    localparam int c_NBITS = DATA_W;
`endif
    localparam int                c_CW      = $clog2(c_NBITS);
    localparam logic [c_CW-1:0]   c_LAST    = c_CW'(c_NBITS - 1);
    localparam logic [c_AW:0]     c_FULL    = (c_AW+1)'(DEPTH);
    localparam logic [c_AW:0]     c_LVL_ONE = (c_AW+1)'(1);

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_level;
    logic [0:0]        r_state;
    logic [DATA_W-1:0] r_shift;
    logic [c_CW-1:0]   r_bit_cnt;

    logic              w_wr;
    logic              w_read;
    logic              w_at_last;
    logic              w_load;
    logic [DATA_W-1:0] w_head;
    logic              w_data_bit;
    logic              w_cur_bit;
    logic [DATA_W-1:0] w_shift_next;

    assign input_rdy  = (r_level != c_FULL);
    assign output_rdy = (r_state == c_ST_SHIFT);
    assign level      = r_level;

    // A full FIFO refuses writes even when a pop happens on the same edge.
    assign w_wr      = wr_in && input_rdy;
    assign w_read    = output_read_in && (r_state == c_ST_SHIFT);
    assign w_at_last = (r_bit_cnt == c_LAST);
    assign w_load    = (r_level != '0) &&
                       ((r_state == c_ST_EMPTY) || (w_read && w_at_last));
    assign w_head    = r_mem[r_rd_ptr];

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_data_bit   = r_shift[DATA_W-1];
            assign w_shift_next = {r_shift[DATA_W-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_data_bit   = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[DATA_W-1:1]};
        end
    endgenerate

`ifdef PISO_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^w_head;
        end
    end

    // The extra cycle after the data bits carries the parity captured at load.
    assign w_cur_bit = w_at_last ? r_parity : w_data_bit;
`else
    assign w_cur_bit = w_data_bit;
`endif

    always_ff @(posedge clk_in) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= parallel_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_state      <= c_ST_EMPTY;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            serial_last  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_wr, w_load})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase

            serial_valid <= w_read;
            serial_last  <= w_read && w_at_last;
            if (w_read) begin
                serial_out <= w_cur_bit;
                r_shift    <= w_shift_next;
                r_bit_cnt  <= r_bit_cnt + c_CW'(1);
            end

            // A load on the final read edge chains the next word with no bubble.
            if (w_load) begin
                r_shift   <= w_head;
                r_bit_cnt <= '0;
                r_state   <= c_ST_SHIFT;
            end else if (w_read && w_at_last) begin
                r_state   <= c_ST_EMPTY;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_stream_out.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_stream_out
//  Description : Directed bench for piso_stream_out (LSB-first and MSB-first
//                instances sharing one input stimulus).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_stream_out;

`ifdef PISO_PARITY_EN
    localparam int c_NB = 33;
`else
    localparam int c_NB = 32;
`endif

    logic        clk = 1'b0;
    logic        rst_in;
    logic [31:0] parallel_in;
    logic        wr_in;
    logic        output_read_in;

    logic       l_irdy, l_ordy, l_out, l_valid, l_last;
    logic [2:0] l_level;
    logic       m_irdy, m_ordy, m_out, m_valid, m_last;
    logic [2:0] m_level;

    piso_stream_out #(.DATA_W(32), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk_in(clk), .rst_in(rst_in), .parallel_in(parallel_in), .wr_in(wr_in),
        .input_rdy(l_irdy), .output_read_in(output_read_in), .output_rdy(l_ordy),
        .serial_out(l_out), .serial_valid(l_valid), .serial_last(l_last),
        .level(l_level)
    );

    piso_stream_out #(.DATA_W(32), .DEPTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk_in(clk), .rst_in(rst_in), .parallel_in(parallel_in), .wr_in(wr_in),
        .input_rdy(m_irdy), .output_read_in(output_read_in), .output_rdy(m_ordy),
        .serial_out(m_out), .serial_valid(m_valid), .serial_last(m_last),
        .level(m_level)
    );

    always #5 clk = ~clk;

    logic use_msb;
    logic s_rdy, s_valid, s_out, s_last;
    assign s_rdy   = use_msb ? m_ordy  : l_ordy;
    assign s_valid = use_msb ? m_valid : l_valid;
    assign s_out   = use_msb ? m_out   : l_out;
    assign s_last  = use_msb ? m_last  : l_last;

    int checks   = 0;
    int failures = 0;

    logic bits_q  [0:255];
    logic lasts_q [0:255];
    int   nvalid;
    int   gaps;

    typedef struct {
        logic [31:0] data;
        logic        msb;
        logic [31:0] exp_stream;   // bit k = k-th serial bit emitted
        logic        exp_par;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Holds read high until nb valid bits arrive on the selected instance.
    task automatic collect(input int nb);
        int  cyc = 0;
        bit  started = 0;
        nvalid = 0;
        gaps   = 0;
        output_read_in = 1'b1;
        while (nvalid < nb && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (s_valid) begin
                bits_q[nvalid]  = s_out;
                lasts_q[nvalid] = s_last;
                nvalid++;
                started = 1;
            end else if (started) begin
                gaps++;
            end
        end
        output_read_in = 1'b0;
        if (nvalid < nb) begin
            checks++;
            failures++;
            $display("FAIL collect_timeout actual=%0d required=%0d", nvalid, nb);
        end
    endtask

    function automatic logic [31:0] word_at(input int base);
        logic [31:0] w;
        for (int k = 0; k < 32; k++) w[k] = bits_q[base + k];
        return w;
    endfunction

    task automatic write_word(input logic [31:0] d);
        wr_in       = 1'b1;
        parallel_in = d;
        @(negedge clk);
        wr_in       = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] words [5];
        int nlast;
        int lastpos;
        int nv, missed, extra, holdbad, guard;
        logic prev;
        logic [31:0] got;

        vecs[0] = '{32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0};
        vecs[1] = '{32'h0000_0007, 1'b0, 32'h0000_0007, 1'b1};
        vecs[2] = '{32'h0000_0003, 1'b0, 32'h0000_0003, 1'b0};
        vecs[3] = '{32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5, 1'b0};
        vecs[4] = '{32'h0000_FFFF, 1'b1, 32'hFFFF_0000, 1'b0};

        use_msb = 1'b0;
        rst_in = 1'b1;
        wr_in = 1'b0;
        parallel_in = '0;
        output_read_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_in = 1'b0;
        @(negedge clk);
        chk("rst_input_rdy",  l_irdy,  1);
        chk("rst_output_rdy", l_ordy,  0);
        chk("rst_level",      l_level, 0);
        chk("rst_valid",      l_valid, 0);
        chk("rst_last",       l_last,  0);
        chk("rst_serial_out", l_out,   0);
        chk("rst_msb_ordy",   m_ordy,  0);

        // Single-word vectors, continuous reads.
        for (int i = 0; i < 5; i++) begin
            use_msb = vecs[i].msb;
            write_word(vecs[i].data);
            chk("vec_rdy_before_load", s_rdy, 0);
            chk("vec_level_after_write", l_level, 1);
            @(negedge clk);
            chk("vec_rdy_after_load", s_rdy, 1);
            chk("vec_level_after_load", l_level, 0);
            collect(c_NB);
            chk("vec_stream", word_at(0), vecs[i].exp_stream);
            chk("vec_gaps", gaps, 0);
`ifdef PISO_PARITY_EN
            chk("vec_parity_bit", bits_q[32], vecs[i].exp_par);
`endif
            nlast = 0;
            lastpos = -1;
            for (int k = 0; k < c_NB; k++) if (lasts_q[k]) begin nlast++; lastpos = k; end
            chk("vec_last_count", nlast, 1);
            chk("vec_last_pos", lastpos, c_NB - 1);
            chk("vec_rdy_drop", s_rdy, 0);
            @(negedge clk);
            chk("vec_valid_idle", s_valid, 0);
        end

        // Back-to-back MSB-first words.
        use_msb = 1'b1;
        wr_in = 1'b1;
        parallel_in = 32'hA5A5_A5A5;
        @(negedge clk);
        parallel_in = 32'h0000_FFFF;
        @(negedge clk);
        wr_in = 1'b0;
        collect(2 * c_NB);
        chk("b2b_gaps", gaps, 0);
        chk("b2b_word0", word_at(0), 32'hA5A5_A5A5);
        chk("b2b_word1", word_at(c_NB), 32'hFFFF_0000);
        nlast = 0;
        for (int k = 0; k < 2 * c_NB; k++) if (lasts_q[k]) nlast++;
        chk("b2b_last_count", nlast, 2);
        chk("b2b_last_a", lasts_q[c_NB - 1], 1);
        chk("b2b_last_b", lasts_q[2 * c_NB - 1], 1);
        @(negedge clk);
        chk("b2b_rdy_drop", m_ordy, 0);

        // Fill: one word in the shifter, four in the FIFO.
        use_msb = 1'b0;
        for (int k = 0; k < 5; k++) words[k] = 32'hC0DE_0000 + 32'(k * 16'h1111);
        for (int k = 0; k < 5; k++) write_word(words[k]);
        chk("full_level", l_level, 4);
        chk("full_input_rdy", l_irdy, 0);
        chk("full_output_rdy", l_ordy, 1);
        write_word(32'hDEAD_BEEF);
        chk("full_ignored_level", l_level, 4);
        collect(c_NB);
        chk("full_word0", word_at(0), words[0]);
        chk("full_level_after", l_level, 3);
        chk("full_input_rdy_after", l_irdy, 1);
        chk("full_chained", l_ordy, 1);
        collect(4 * c_NB);
        chk("full_drain_gaps", gaps, 0);
        chk("full_word1", word_at(0), words[1]);
        chk("full_word4", word_at(3 * c_NB), words[4]);
        @(negedge clk);
        chk("full_empty_rdy", l_ordy, 0);
        chk("full_empty_level", l_level, 0);

        // Throttled reads: 1,0,1,0 over a single word.
        write_word(32'h0000_0003);
        @(negedge clk);
        nv = 0; missed = 0; extra = 0; holdbad = 0; guard = 0; prev = 1'b0;
        got = '0;
        while (l_ordy && guard < 100) begin
            output_read_in = 1'b1;
            @(negedge clk);
            guard++;
            if (l_valid) begin
                if (nv < 32) got[nv] = l_out;
                nv++;
                prev = l_out;
            end else begin
                missed++;
            end
            output_read_in = 1'b0;
            @(negedge clk);
            if (l_valid) extra++;
            if (l_out !== prev) holdbad++;
        end
        chk("thr_count", nv, c_NB);
        chk("thr_missed", missed, 0);
        chk("thr_idle_valid", extra, 0);
        chk("thr_hold", holdbad, 0);
        chk("thr_stream", got, 32'h0000_0003);

        // Reset in the middle of a word with a second word queued.
        write_word(32'h1234_5678);
        write_word(32'h9ABC_DEF0);
        output_read_in = 1'b1;
        repeat (5) @(negedge clk);
        output_read_in = 1'b0;
        rst_in = 1'b1;
        @(negedge clk);
        chk("mid_rst_input_rdy",  l_irdy,  1);
        chk("mid_rst_output_rdy", l_ordy,  0);
        chk("mid_rst_level",      l_level, 0);
        chk("mid_rst_valid",      l_valid, 0);
        chk("mid_rst_serial_out", l_out,   0);
        rst_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_discarded", l_ordy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_stream_out.md
Name: piso_stream_out

Overview:
- Parametrised parallel-in/serial-out output stage. It buffers up to DEPTH words and streams them bit-serially, one bit per accepted read cycle.
- Consecutive words stream back-to-back with no idle cycle between them.
- Sits at the adder result boundary: the core writes results in parallel, and the external pin-limited reader drains them serially.

Parameters:
- DATA_W, 32, word width in bits (>= 2).
- DEPTH, 4, word FIFO depth (power of 2, >= 2).
- MSB_FIRST, 0, 0 = bit 0 shifted out first; 1 = bit DATA_W-1 first.

Ports:
- clk_in  in  1  clock, all logic on rising edge.
- rst_in  in  1  synchronous reset, active-high.
- parallel_in  in  DATA_W  word to enqueue.
- wr_in  in  1  write request.
- input_rdy  out  1  FIFO not full; a write is accepted when wr_in && input_rdy.
- output_read_in  in  1  read request for the next serial bit.
- output_rdy  out  1  shifter holds a word with bits remaining.
- serial_out  out  1  registered serial data bit.
- serial_valid  out  1  serial_out carries a bit shifted on the previous edge.
- serial_last  out  1  with serial_valid, marks the final bit of a word.
- level  out  $clog2(DEPTH)+1  words held in the FIFO (excludes the word in the shifter).

Behaviour:
- Reset (sync, rst_in=1 at an edge): FIFO pointers, level and bit counter go to 0; shifter is empty.
  - Outputs after reset: input_rdy=1, output_rdy=0, serial_out=0, serial_valid=0, serial_last=0, level=0.
  - Reset mid-word discards both the partial word and the FIFO contents.
- FIFO:
  - Write accepted: the word is stored at the write pointer and level increments.
  - input_rdy = (level != DEPTH) and is derived from registered level. A write on a full cycle is ignored even if a pop happens in the same cycle; there is no write-through.
  - Pointers wrap modulo DEPTH.
- Shifter states:
  - EMPTY:
    - If level > 0, load the FIFO head at the next edge (pop, level-1, bit_cnt=0) and go to SHIFT.
    - output_rdy=0.
  - SHIFT:
    - output_rdy=1.
    - On an edge with output_read_in=1: serial_out <= current bit (LSB or MSB per MSB_FIRST); serial_valid <= 1; bit_cnt increments.
    - On a read edge with bit_cnt = DATA_W-1, serial_last <= 1.
      - If level > 0, load the next FIFO word on that same edge and stay in SHIFT (no bubble).
      - Otherwise go to EMPTY.
    - On an edge with output_read_in=0: serial_out holds; serial_valid and serial_last go to 0.
- output_read_in while output_rdy=0 is ignored; serial_valid=0 afterwards.
- Latency: a write accepted at edge t into an empty block loads at edge t+1. output_rdy is high after t+1, and the first serial_valid follows the first read edge.
- Simultaneous write and load/pop in one cycle:
  - Level is unchanged.
  - Both operations take effect.
- Throughput: one bit per clock sustained. Word count is limited only by FIFO occupancy.

Optional Feature:
- Macro PISO_PARITY_EN.
- When defined:
  - Each word is followed by one extra serial bit: even parity (XOR of all DATA_W bits).
  - serial_last marks the parity bit, so a word occupies DATA_W+1 read cycles.
  - The bit counter is widened to match.
- When undefined: exactly DATA_W bits per word and no parity logic is synthesised.

Test Plan:
- Reset then idle:
  - rst_in=1 for 2 cycles, then 0 -> input_rdy=1, output_rdy=0, level=0, serial_valid=0.
  - Reset asserted mid-word -> same values on the next edge.
- Single word, LSB first, DATA_W=32:
  - Write 0x8000_0001, then hold output_read_in=1 -> output_rdy high 1 edge after the write.
  - serial_out sequence is 1, then 30 zeros, then 1.
  - serial_last is high only on the 32nd valid bit; output_rdy then drops.
- Back-to-back words, MSB_FIRST=1:
  - Write 0xA5A5_A5A5 then 0x0000_FFFF, continuous reads -> 64 consecutive valid bits with no gap.
  - serial_last is high on bits 32 and 64.
- Full FIFO, DEPTH=4:
  - Write 5 words with no reads -> 1 word in the shifter and level=4; input_rdy=0.
  - A 6th wr_in is ignored.
  - After the shifter finishes its word -> level=3 and input_rdy returns to 1.
- Throttled read:
  - Toggle output_read_in 1,0,1,0 over word 0x0000_0003 -> serial_valid follows each read edge.
  - serial_out holds on idle cycles.
  - Exactly 32 valid bits are delivered.
- Parity (PISO_PARITY_EN):
  - Write 0x0000_0007 -> 33 bits delivered; the 33rd bit is 1 and carries serial_last.
  - Write 0x0000_0003 -> 33rd bit is 0.
